// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport general-register file.
// Holds the sequencer state encoding and the index-width helper.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gr_multiport_if.sv
// Read, write and scoreboard signals of the register file, bundled as one port.
// The master side drives indices and write data; the slave side is the register file.
interface gr_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy1;
    logic              busy2;
    logic              we_a;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              we_b;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic              init_done;

    modport master (
        output rd_addr1, rd_addr2, we_a, wa_addr, wa_data,
               we_b, wb_addr, wb_data, busy_set, busy_addr,
        input  rd_data1, rd_data2, busy1, busy2, init_done
    );

    modport slave (
        input  rd_addr1, rd_addr2, we_a, wa_addr, wa_data,
               we_b, wb_addr, wb_data, busy_set, busy_addr,
        output rd_data1, rd_data2, busy1, busy2, init_done
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: two clear ports (one per write port) and one set port.
// A set and a clear of the same index in one cycle leaves the bit set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_a_i,
    input  logic [ADDR_W-1:0] clr_a_addr_i,
    input  logic              clr_b_i,
    input  logic [ADDR_W-1:0] clr_b_addr_i,
    output logic [DEPTH-1:0]  busy_o
);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_a_i) busy_d[clr_a_addr_i] = 1'b0;
        if (clr_b_i) busy_d[clr_b_addr_i] = 1'b0;
        // Set is applied last so an issue in the same cycle as the write-back wins.
        if (set_i)   busy_d[set_addr_i]   = 1'b1;
        if (ZERO_EN) busy_d[REG_ZERO]     = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/gr_multiport.sv
// Two-read, two-write general-register file with same-cycle bypass and busy scoreboard.
// After reset an internal sequencer clears every register over DEPTH cycles before use.
module gr_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gr_multiport_if.slave   bus
);
    localparam bit              ZERO_EN  = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic              run;
    logic              wa_ok;
    logic              wb_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == ADDR_W'(REG_ZERO));
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic: write qualification, bypassed reads, busy lookup
    always_comb begin
        run   = (state_q == ST_RUN);
        wa_ok = run && bus.we_a && !is_zero(bus.wa_addr);
        wb_ok = run && bus.we_b && !is_zero(bus.wb_addr);

        bus.init_done = run;
        bus.busy1     = run && busy_vec[bus.rd_addr1];
        bus.busy2     = run && busy_vec[bus.rd_addr2];

        bus.rd_data1 = '0;
        if (run && !is_zero(bus.rd_addr1)) begin
            if (wb_ok && bus.wb_addr == bus.rd_addr1)      bus.rd_data1 = bus.wb_data;
            else if (wa_ok && bus.wa_addr == bus.rd_addr1) bus.rd_data1 = bus.wa_data;
            else                                           bus.rd_data1 = mem_q[bus.rd_addr1];
        end

        bus.rd_data2 = '0;
        if (run && !is_zero(bus.rd_addr2)) begin
            if (wb_ok && bus.wb_addr == bus.rd_addr2)      bus.rd_data2 = bus.wb_data;
            else if (wa_ok && bus.wa_addr == bus.rd_addr2) bus.rd_data2 = bus.wa_data;
            else                                           bus.rd_data2 = mem_q[bus.rd_addr2];
        end
    end

    // Storage has no reset of its own; the INIT sequencer clears it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                mem_q[idx_q[ADDR_W-1:0]] <= '0;
            end else begin
                if (wa_ok) mem_q[bus.wa_addr] <= bus.wa_data;
                // Port B assigned last so it wins on an address collision.
                if (wb_ok) mem_q[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_i        (run && bus.busy_set),
        .set_addr_i   (bus.busy_addr),
        .clr_a_i      (wa_ok),
        .clr_a_addr_i (bus.wa_addr),
        .clr_b_i      (wb_ok),
        .clr_b_addr_i (bus.wb_addr),
        .busy_o       (busy_vec)
    );

endmodule
